// File: rtl/canny_pkg.sv
// Shared field layout, class/direction codes and datapath widths for the Canny
// gradient encoder.
package canny_pkg;

  localparam int DIR_MSB = 14;
  localparam int CLS_MSB = 12;
  localparam int MAG_MSB = 10;

  localparam int GRAD_W = 11;
  localparam int ABS_W  = 10;
  localparam int MAG_W  = 11;
  localparam int TH_W   = 11;

  localparam logic [1:0] CLS_BLANK  = 2'b00;
  localparam logic [1:0] CLS_SUPP   = 2'b01;
  localparam logic [1:0] CLS_WEAK   = 2'b10;
  localparam logic [1:0] CLS_STRONG = 2'b11;

  localparam logic [1:0] DIR_H   = 2'b00;
  localparam logic [1:0] DIR_45  = 2'b01;
  localparam logic [1:0] DIR_V   = 2'b10;
  localparam logic [1:0] DIR_135 = 2'b11;

  localparam int TAN22_NUM = 106;
  localparam int TAN_SHIFT = 8;

  typedef struct packed {
    logic [DIR_MSB:CLS_MSB+1] dir;
    logic [CLS_MSB:MAG_MSB+1] cls;
    logic [MAG_MSB:0]         mag;
  } canny_word_t;

endpackage

// File: rtl/canny_grad_encoder_dir_quant.sv
// Combinational gradient-direction quantiser: maps |Gx|, |Gy| and their signs
// onto one of four NMS comparison axes using tan(22.5) ~ 106/256.
module canny_dir_quant
  import canny_pkg::*;
(
  input  logic [ABS_W-1:0] ax,
  input  logic [ABS_W-1:0] ay,
  input  logic             sx,
  input  logic             sy,
  output logic [1:0]       dir
);

  logic [17:0] ax_sh, ay_sh, ax_tan, ay_tan;

  always_comb begin
    ax_sh  = 18'(ax) << TAN_SHIFT;
    ay_sh  = 18'(ay) << TAN_SHIFT;
    ax_tan = 18'(ax) * 18'(TAN22_NUM);
    ay_tan = 18'(ay) * 18'(TAN22_NUM);
    dir    = DIR_H;
    // A zero gradient lands in the first branch and reports horizontal.
    if (ay_sh <= ax_tan)
      dir = DIR_H;
    else if (ax_sh <= ay_tan)
      dir = DIR_V;
    else if (sx == sy)
      dir = DIR_135;
    else
      dir = DIR_45;
  end

endmodule

// File: rtl/canny_grad_encoder.sv
// Sobel gradient, L1 magnitude, direction and double-threshold class packed into
// one 15-bit word per pixel, 3-cycle latency. Optional macro CANNY_GRAD_STATS_EN
// adds a per-frame strong-pixel counter on o_strong_cnt.
module canny_grad_encoder
  import canny_pkg::*;
#(
  parameter int              PIX_W        = 8,
  parameter logic [TH_W-1:0] LOW_TH_RST   = 11'd100,
  parameter logic [TH_W-1:0] HIGH_TH_RST  = 11'd200,
  parameter logic            VSYNC_ACTIVE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_HSYNC,
  input  logic             i_VSYNC,
  input  logic             i_BLANK,
  input  logic [PIX_W-1:0] i_matrix11,
  input  logic [PIX_W-1:0] i_matrix12,
  input  logic [PIX_W-1:0] i_matrix13,
  input  logic [PIX_W-1:0] i_matrix21,
  input  logic [PIX_W-1:0] i_matrix22,
  input  logic [PIX_W-1:0] i_matrix23,
  input  logic [PIX_W-1:0] i_matrix31,
  input  logic [PIX_W-1:0] i_matrix32,
  input  logic [PIX_W-1:0] i_matrix33,
  input  logic [TH_W-1:0]  i_low_th,
  input  logic [TH_W-1:0]  i_high_th,
  output logic             o_HSYNC,
  output logic             o_VSYNC,
  output logic             o_BLANK,
  output logic [14:0]      o_canny
`ifdef CANNY_GRAD_STATS_EN
  ,
  output logic [19:0]      o_strong_cnt
`endif
);

  function automatic logic signed [GRAD_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
    return $signed(GRAD_W'(p));
  endfunction

  function automatic logic [ABS_W-1:0] grad_abs(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? ABS_W'(-g) : ABS_W'(g);
  endfunction

  logic signed [GRAD_W-1:0] gx_c, gy_c, gx_p0, gy_p0;
  logic                     hsync_p0, vsync_p0, blank_p0;
  logic [ABS_W-1:0]         ax_c, ay_c, ax_p1, ay_p1;
  logic [MAG_W-1:0]         mag_c, mag_p1;
  logic                     sx_p1, sy_p1;
  logic                     hsync_p1, vsync_p1, blank_p1;
  logic [1:0]               dir_c, cls_c;
  canny_word_t              word_c;
  logic [TH_W-1:0]          low_th_sh, high_th_sh;
  logic                     vsync_q, vs_edge;
  logic                     unused_center;

  // The Sobel kernels do not weight the centre pixel.
  assign unused_center = ^i_matrix22;

  assign gx_c = (pix_ext(i_matrix13) + (pix_ext(i_matrix23) <<< 1) + pix_ext(i_matrix33))
              - (pix_ext(i_matrix11) + (pix_ext(i_matrix21) <<< 1) + pix_ext(i_matrix31));
  assign gy_c = (pix_ext(i_matrix31) + (pix_ext(i_matrix32) <<< 1) + pix_ext(i_matrix33))
              - (pix_ext(i_matrix11) + (pix_ext(i_matrix12) <<< 1) + pix_ext(i_matrix13));

  // Stage 1: Sobel gradients
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_p0    <= '0;
      gy_p0    <= '0;
      hsync_p0 <= 1'b0;
      vsync_p0 <= 1'b0;
      blank_p0 <= 1'b0;
    end else begin
      gx_p0    <= gx_c;
      gy_p0    <= gy_c;
      hsync_p0 <= i_HSYNC;
      vsync_p0 <= i_VSYNC;
      blank_p0 <= i_BLANK;
    end
  end

  assign ax_c  = grad_abs(gx_p0);
  assign ay_c  = grad_abs(gy_p0);
  assign mag_c = MAG_W'(ax_c) + MAG_W'(ay_c);

  // Stage 2: absolute values, signs and L1 magnitude
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ax_p1    <= '0;
      ay_p1    <= '0;
      sx_p1    <= 1'b0;
      sy_p1    <= 1'b0;
      mag_p1   <= '0;
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
      blank_p1 <= 1'b0;
    end else begin
      ax_p1    <= ax_c;
      ay_p1    <= ay_c;
      sx_p1    <= gx_p0[GRAD_W-1];
      sy_p1    <= gy_p0[GRAD_W-1];
      mag_p1   <= mag_c;
      hsync_p1 <= hsync_p0;
      vsync_p1 <= vsync_p0;
      blank_p1 <= blank_p0;
    end
  end

  canny_dir_quant u_dir_quant (
    .ax  (ax_p1),
    .ay  (ay_p1),
    .sx  (sx_p1),
    .sy  (sy_p1),
    .dir (dir_c)
  );

  // With low above high the weak band is empty; thresholds are used unswapped.
  always_comb begin
    cls_c = CLS_SUPP;
    if (mag_p1 >= high_th_sh)
      cls_c = CLS_STRONG;
    else if (mag_p1 >= low_th_sh)
      cls_c = CLS_WEAK;
    word_c = '0;
    if (blank_p1) begin
      word_c.dir = dir_c;
      word_c.cls = cls_c;
      word_c.mag = mag_p1;
    end
  end

  // Stage 3: quantise, classify, pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_canny <= '0;
      o_HSYNC <= 1'b0;
      o_VSYNC <= 1'b0;
      o_BLANK <= 1'b0;
    end else begin
      o_canny <= word_c;
      o_HSYNC <= hsync_p1;
      o_VSYNC <= vsync_p1;
      o_BLANK <= blank_p1;
    end
  end

  // Edge detector idles at the active level so a reset never fakes a frame start.
  assign vs_edge = (i_VSYNC == VSYNC_ACTIVE) && (vsync_q != VSYNC_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= VSYNC_ACTIVE;
      low_th_sh  <= LOW_TH_RST;
      high_th_sh <= HIGH_TH_RST;
    end else begin
      vsync_q <= i_VSYNC;
      if (vs_edge) begin
        low_th_sh  <= i_low_th;
        high_th_sh <= i_high_th;
      end
    end
  end

`ifdef CANNY_GRAD_STATS_EN
  function automatic logic [19:0] sat_inc(input logic [19:0] v);
    return (&v) ? v : v + 20'd1;
  endfunction

  logic [19:0] strong_cnt;
  logic        strong_hit;

  assign strong_hit = blank_p1 && (cls_c == CLS_STRONG);

  // A strong pixel coinciding with the frame edge opens the new frame's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strong_cnt   <= '0;
      o_strong_cnt <= '0;
    end else if (vs_edge) begin
      o_strong_cnt <= strong_cnt;
      strong_cnt   <= strong_hit ? 20'd1 : 20'd0;
    end else if (strong_hit) begin
      strong_cnt   <= sat_inc(strong_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_canny_grad_encoder.sv
// Randomized and directed bench for canny_grad_encoder against a frame-level
// reference model; define CANNY_GRAD_STATS_EN to also cover o_strong_cnt.
module tb_canny_grad_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hs, vs, bl;
  logic [7:0]  win [9];
  logic [10:0] lo_in, hi_in;
  logic        o_h, o_v, o_b;
  logic [14:0] o_canny;
`ifdef CANNY_GRAD_STATS_EN
  logic [19:0] o_cnt;
`endif

  always #5 clk = ~clk;

  canny_grad_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_HSYNC    (hs),
    .i_VSYNC    (vs),
    .i_BLANK    (bl),
    .i_matrix11 (win[0]),
    .i_matrix12 (win[1]),
    .i_matrix13 (win[2]),
    .i_matrix21 (win[3]),
    .i_matrix22 (win[4]),
    .i_matrix23 (win[5]),
    .i_matrix31 (win[6]),
    .i_matrix32 (win[7]),
    .i_matrix33 (win[8]),
    .i_low_th   (lo_in),
    .i_high_th  (hi_in),
    .o_HSYNC    (o_h),
    .o_VSYNC    (o_v),
    .o_BLANK    (o_b),
    .o_canny    (o_canny)
`ifdef CANNY_GRAD_STATS_EN
    ,
    .o_strong_cnt (o_cnt)
`endif
  );

  typedef struct packed {
    logic [14:0] w;
    logic        h;
    logic        v;
    logic        b;
  } exp_t;

  exp_t exq [$];
  int   compared = 0;
  int   mismatched = 0;
  int   sh_lo, sh_hi, frame_strong, exp_cnt;
  logic prev_v;

  // Reference: Sobel, L1 magnitude, 22.5-degree sectors, double threshold.
  function automatic logic [14:0] ref_word(input logic [7:0] w [9], input logic b,
                                           input int lo, input int hi);
    int gx, gy, ax, ay, mag;
    logic [1:0] d, c;
    if (!b) return 15'd0;
    gx  = (w[2] + 2 * w[5] + w[8]) - (w[0] + 2 * w[3] + w[6]);
    gy  = (w[6] + 2 * w[7] + w[8]) - (w[0] + 2 * w[1] + w[2]);
    ax  = (gx < 0) ? -gx : gx;
    ay  = (gy < 0) ? -gy : gy;
    mag = ax + ay;
    if (ay * 256 <= ax * 106)      d = 2'b00;
    else if (ax * 256 <= ay * 106) d = 2'b10;
    else if ((gx >= 0) == (gy >= 0)) d = 2'b11;
    else                           d = 2'b01;
    if (mag >= hi)      c = 2'b11;
    else if (mag >= lo) c = 2'b10;
    else                c = 2'b01;
    return {d, c, 11'(mag)};
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exq.delete();
    exq.push_back('0);
    exq.push_back('0);
    sh_lo = 100;
    sh_hi = 200;
    prev_v = 1'b0;
    frame_strong = 0;
    exp_cnt = 0;
  endtask

  task automatic step();
    logic [14:0] w;
    logic        e;
    exp_t        x;
    e = (vs == 1'b0) && (prev_v == 1'b1);
    prev_v = vs;
    if (e) begin
      sh_lo = int'(lo_in);
      sh_hi = int'(hi_in);
      exp_cnt = frame_strong;
      frame_strong = 0;
    end
    w = ref_word(win, bl, sh_lo, sh_hi);
    if (w[12:11] == 2'b11) frame_strong++;
    x.w = w; x.h = hs; x.v = vs; x.b = bl;
    exq.push_back(x);
    @(posedge clk);
    #1;
    x = exq.pop_front();
    check("canny", 32'(o_canny), 32'(x.w));
    check("sync", {29'd0, o_h, o_v, o_b}, {29'd0, x.h, x.v, x.b});
`ifdef CANNY_GRAD_STATS_EN
    check("strong_cnt", 32'(o_cnt), 32'(exp_cnt));
`endif
  endtask

  task automatic hold(input logic [7:0] w [9]);
    win = w;
    repeat (3) step();
  endtask

  task automatic frame_edge(input logic [10:0] lo, input logic [10:0] hi);
    bl = 1'b0;
    vs = 1'b1;
    repeat (3) step();
    vs = 1'b0;
    lo_in = lo;
    hi_in = hi;
    step();
    lo_in = 11'($urandom);
    hi_in = 11'($urandom);
    step();
    vs = 1'b1;
    step();
  endtask

  task automatic rand_window();
    int mode, base, v;
    mode = $urandom_range(0, 2);
    base = $urandom_range(0, 255);
    for (int i = 0; i < 9; i++) begin
      if (mode == 0) v = $urandom_range(0, 255);
      else if (mode == 1) v = base + $urandom_range(0, 40);
      else v = base;
      win[i] = (v > 255) ? 8'd255 : 8'(v);
    end
  endtask

  logic [7:0] w_step [9];
  logic [7:0] w_flat [9];
  logic [7:0] w_diag [9];
  logic [7:0] w_mirr [9];
  logic [7:0] w_m100 [9];

  initial begin
    w_step = '{8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd255, 8'd255};
    w_flat = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128, 8'd128};
    w_diag = '{8'd0, 8'd22, 8'd45, 8'd22, 8'd45, 8'd68, 8'd45, 8'd68, 8'd90};
    w_mirr = '{8'd45, 8'd22, 8'd0, 8'd68, 8'd45, 8'd22, 8'd90, 8'd68, 8'd45};
    w_m100 = '{8'd0, 8'd0, 8'd25, 8'd0, 8'd0, 8'd25, 8'd0, 8'd0, 8'd25};

    rst_n = 1'b0;
    hs = 1'b0;
    vs = 1'b1;
    bl = 1'b0;
    lo_in = 11'd0;
    hi_in = 11'd0;
    win = w_step;
    repeat (2) @(posedge clk);
    #1;
    check("reset_canny", 32'(o_canny), 32'd0);
    check("reset_sync", {29'd0, o_h, o_v, o_b}, 32'd0);
`ifdef CANNY_GRAD_STATS_EN
    check("reset_cnt", 32'(o_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    model_reset();

    // Reset-value thresholds 100/200 before any frame edge.
    bl = 1'b1;
    lo_in = 11'd2047;
    hi_in = 11'd2047;
    hold(w_step);
    check("vert_step", 32'(o_canny), 32'h1BFC);
    hold(w_flat);
    check("flat", 32'(o_canny), 32'h0800);

    frame_edge(11'd100, 11'd200);
    bl = 1'b1;
    hold(w_diag);
    check("diag_dir", 32'(o_canny[14:13]), 32'd3);
    hold(w_mirr);
    check("mirror_dir", 32'(o_canny[14:13]), 32'd1);
    hold(w_m100);
    check("mag100_weak", 32'(o_canny), 32'h1064);
    hi_in = 11'd50;
    hold(w_m100);
    check("midframe_th", 32'(o_canny), 32'h1064);
    frame_edge(11'd100, 11'd50);
    bl = 1'b1;
    hold(w_m100);
    check("nextframe_th", 32'(o_canny), 32'h1864);

    bl = 1'b0;
    hs = 1'b1;
    hold(w_step);
    check("blank_canny", 32'(o_canny), 32'd0);
    check("blank_flag", 32'(o_b), 32'd0);
    hs = 1'b0;

    // 37 active strong windows among 5 blanked strong ones.
    frame_edge(11'd100, 11'd200);
    win = w_step;
    for (int i = 0; i < 42; i++) begin
      bl = (i % 8 != 7);
      step();
    end
    frame_edge(11'd100, 11'd200);
`ifdef CANNY_GRAD_STATS_EN
    check("strong37", 32'(o_cnt), 32'd37);
`endif

    for (int f = 0; f < 6; f++) begin
      frame_edge(11'($urandom_range(0, 900)), 11'($urandom_range(0, 1200)));
      for (int p = 0; p < 200; p++) begin
        rand_window();
        bl = ($urandom_range(0, 9) < 8);
        hs = $urandom_range(0, 1) == 1;
        lo_in = 11'($urandom);
        hi_in = 11'($urandom);
        step();
      end
    end
    frame_edge(11'd300, 11'd400);

    // Asynchronous reset in the middle of an active line.
    bl = 1'b1;
    hs = 1'b1;
    win = w_step;
    repeat (4) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_canny", 32'(o_canny), 32'd0);
    check("async_rst_sync", {29'd0, o_h, o_v, o_b}, 32'd0);
`ifdef CANNY_GRAD_STATS_EN
    check("async_rst_cnt", 32'(o_cnt), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    hs = 1'b0;
    hold(w_m100);
    check("post_rst_shadow", 32'(o_canny), 32'h1064);
    for (int p = 0; p < 50; p++) begin
      rand_window();
      bl = ($urandom_range(0, 3) != 0);
      hs = $urandom_range(0, 1) == 1;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
